bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles without s_ack before a transfer is aborted with a bus error.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have ports clk (input, 1): single system clock; all state changes on its rising edge.
REQ-004 SHALL have ports reset_n (input, 1): asynchronous, active-low reset.
REQ-005 SHALL have ports m0_as, m1_as (input, 1 each): requester address strobe, active-high; m0 = CPU, m1 = DMA.
REQ-006 SHALL have ports m0_addr, m1_addr (input, AW each): requester address.
REQ-007 SHALL have ports m0_write, m1_write (input, 16 each): requester write data.
REQ-008 SHALL have ports m0_uds, m0_lds, m1_uds, m1_lds (input, 1 each): active-high byte enables; uds = data[15:8], lds = data[7:0].
REQ-009 SHALL have ports m0_rw, m1_rw (input, 1 each): 1 = read, 0 = write.
REQ-010 SHALL have ports m0_read, m1_read (output, 16 each): read data.
REQ-011 SHALL have ports m0_ack, m1_ack (output, 1 each): transfer done.
REQ-012 SHALL have ports m0_berr, m1_berr (output, 1 each): one-cycle bus-error pulse.
REQ-013 SHALL have ports s_as, s_addr[AW], s_write[16], s_uds, s_lds, s_rw (outputs): shared slave-side (device_mux master-port) signals.
REQ-014 SHALL have ports s_read (input, 16) and s_ack (input, 1): shared slave-side return signals.

Function
REQ-015 SHALL implement states IDLE, BUSY0, BUSY1, RELEASE.
REQ-016 In IDLE, a single m0_as or m1_as SHALL move the FSM to BUSY0 or BUSY1 respectively on the next edge.
REQ-017 When both request in IDLE, the arbiter SHALL grant the master not recorded in last_grant, then set last_grant to the granted master.
REQ-018 In BUSYn, s_addr/s_write/s_uds/s_lds/s_rw SHALL combinationally follow master n, and s_as SHALL equal mn_as.
REQ-019 In IDLE and RELEASE, s_as, s_uds and s_lds SHALL be 0.
REQ-020 mn_ack SHALL equal s_ack only in BUSYn and 0 otherwise; the non-granted master SHALL see ack=0 and read=0.
REQ-021 mn_read SHALL equal s_read in BUSYn and 0 otherwise.
REQ-022 In BUSYn, s_ack=1 SHALL move the FSM to RELEASE; RELEASE SHALL hold until mn_as=0, then go to IDLE; grant latency is therefore 1 cycle and the minimum idle gap is 1 cycle.
REQ-023 In BUSYn, a master dropping mn_as before ack (abandon) SHALL return the FSM to IDLE on the next edge.
REQ-024 A timeout counter SHALL clear on entering BUSYn and increment each BUSY cycle with s_ack=0.
REQ-025 When the counter reaches TIMEOUT, mn_berr SHALL pulse for exactly 1 cycle, s_as SHALL drop, and the FSM SHALL enter RELEASE.
REQ-026 s_ack and timeout in the same cycle SHALL resolve as ack; berr SHALL NOT fire.
REQ-027 The counter SHALL be wide enough for TIMEOUT without wrap; TIMEOUT=0 SHALL disable the timeout.
REQ-028 A new request from the same master while in RELEASE SHALL be ignored until IDLE.

Reset
REQ-029 Asserting reset_n=0 SHALL asynchronously force state=IDLE, counter=0, last_grant=m1 (so m0 wins the first contest), all ack/berr=0, and s_as/s_uds/s_lds=0.
REQ-030 Reset mid-transfer SHALL abort without any ack or berr pulse.

Structure
REQ-031 State encoding and the TIMEOUT default SHALL live in shared package bus_pkg.
REQ-032 The timeout counter SHALL be sub-module bus_timeout (inputs clear, enable; output expired).

Verification
REQ-033 Bench SHALL check: m0 read $000400 alone, slave acks on cycle 3 -> s_as on cycle 1, m0_read=s_read, m0_ack on cycle 3, m1_ack=0.
REQ-034 Bench SHALL check: m0 and m1 request in the same cycle after reset -> m0 granted first; then both again -> m1 granted (round-robin).
REQ-035 Bench SHALL check: with TIMEOUT=8, a slave that never acks -> m1_berr high exactly 1 cycle after 8 BUSY cycles, s_as low, FSM in RELEASE until m1_as=0.
REQ-036 Bench SHALL check: s_ack coincides with the timeout cycle -> ack delivered, berr=0.
REQ-037 Bench SHALL check: reset_n pulled low in BUSY0 -> outputs zero immediately (asynchronous), then an m1 request is granted first.
REQ-038 Bench SHALL check: m0 write $00AA with uds=0, lds=1 -> s_lds=1, s_uds=0, s_write=$00AA, s_rw=0.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master bus arbiter:
//   - bus_state_t     : arbiter FSM state encoding
//   - TIMEOUT_DEFAULT : default number of un-acked BUSY cycles before abort
//   - GRANT_M0/M1     : encoding of a master identity (last grant, release owner)
//   - cnt_width()     : counter width able to hold a given limit without wrap
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY0   = 2'd1,
        ST_BUSY1   = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // Smallest width that can represent 0..limit; at least one bit.
    function automatic int cnt_width(input int limit);
        if (limit < 2) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// -----------------------------------------------------------------------------
// bus_timeout
// Saturating cycle counter that flags when a transfer has waited TIMEOUT
// cycles for an acknowledge. TIMEOUT = 0 disables the function entirely.
//
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (counter -> 0)
//   clear    in  synchronous clear (held while no transfer is in progress)
//   enable   in  count this cycle (transfer in progress, no acknowledge)
//   expired  out counter has reached TIMEOUT
// -----------------------------------------------------------------------------
module bus_timeout
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            // No counter at all: the abort path can never trigger.
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset_n, clear, enable};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int              CW    = cnt_width(TIMEOUT);
            localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

            logic [CW-1:0] r_count;

            // Saturates at LIMIT so a stalled transfer can never wrap back
            // to a "fresh" count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable && (r_count != LIMIT)) begin
                    r_count <= r_count + CW'(1);
                end
            end

            assign expired = (r_count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master (m0 = CPU, m1 = DMA) arbiter in front of a single shared slave
// port. Grants one master at a time, routes its request to the slave side
// combinationally, returns read data / acknowledge only to the owner, and
// aborts stalled transfers with a one-cycle bus-error pulse.
//
// Parameters:
//   TIMEOUT  un-acked BUSY cycles before abort (0 = never abort)
//   AW       address width
//
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   m0_/m1_ as, addr, write, uds, lds, rw requester inputs
//   m0_/m1_ read, ack, berr               requester responses
//   s_as, s_addr, s_write, s_uds, s_lds,
//   s_rw                                  shared slave-side request
//   s_read, s_ack                         shared slave-side response
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          m0_as,
    input  logic [AW-1:0] m0_addr,
    input  logic [15:0]   m0_write,
    input  logic          m0_uds,
    input  logic          m0_lds,
    input  logic          m0_rw,
    output logic [15:0]   m0_read,
    output logic          m0_ack,
    output logic          m0_berr,

    input  logic          m1_as,
    input  logic [AW-1:0] m1_addr,
    input  logic [15:0]   m1_write,
    input  logic          m1_uds,
    input  logic          m1_lds,
    input  logic          m1_rw,
    output logic [15:0]   m1_read,
    output logic          m1_ack,
    output logic          m1_berr,

    output logic          s_as,
    output logic [AW-1:0] s_addr,
    output logic [15:0]   s_write,
    output logic          s_uds,
    output logic          s_lds,
    output logic          s_rw,
    input  logic [15:0]   s_read,
    input  logic          s_ack
);

    bus_state_t r_state;
    bus_state_t w_state_next;
    logic       r_last_grant;
    logic       w_last_grant_next;
    logic       r_rel_owner;
    logic       w_rel_owner_next;

    logic       w_busy;
    logic       w_expired;
    logic       w_tmo_hit;

    assign w_busy    = (r_state == ST_BUSY0) || (r_state == ST_BUSY1);
    // An acknowledge in the expiry cycle wins: the transfer completed.
    assign w_tmo_hit = w_expired && !s_ack;

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!w_busy),
        .enable  (w_busy && !s_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_M1;   // m0 wins the first contest
            r_rel_owner  <= GRANT_M0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_rel_owner  <= w_rel_owner_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_rel_owner_next  = r_rel_owner;

        s_as    = 1'b0;
        s_addr  = '0;
        s_write = '0;
        s_uds   = 1'b0;
        s_lds   = 1'b0;
        s_rw    = 1'b1;
        m0_read = '0;
        m0_ack  = 1'b0;
        m0_berr = 1'b0;
        m1_read = '0;
        m1_ack  = 1'b0;
        m1_berr = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (m0_as && m1_as) begin
                    // Contest: the master that did not win last time goes.
                    if (r_last_grant == GRANT_M1) begin
                        w_state_next      = ST_BUSY0;
                        w_last_grant_next = GRANT_M0;
                    end else begin
                        w_state_next      = ST_BUSY1;
                        w_last_grant_next = GRANT_M1;
                    end
                end else if (m0_as) begin
                    w_state_next = ST_BUSY0;
                end else if (m1_as) begin
                    w_state_next = ST_BUSY1;
                end
            end

            ST_BUSY0: begin
                s_addr  = m0_addr;
                s_write = m0_write;
                s_uds   = m0_uds;
                s_lds   = m0_lds;
                s_rw    = m0_rw;
                s_as    = m0_as && !w_tmo_hit;
                m0_read = s_read;
                m0_ack  = s_ack;
                // A master that already walked away gets no error pulse.
                m0_berr = m0_as && w_tmo_hit;
                if (s_ack || (m0_as && w_tmo_hit)) begin
                    w_state_next     = ST_RELEASE;
                    w_rel_owner_next = GRANT_M0;
                end else if (!m0_as) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_BUSY1: begin
                s_addr  = m1_addr;
                s_write = m1_write;
                s_uds   = m1_uds;
                s_lds   = m1_lds;
                s_rw    = m1_rw;
                s_as    = m1_as && !w_tmo_hit;
                m1_read = s_read;
                m1_ack  = s_ack;
                m1_berr = m1_as && w_tmo_hit;
                if (s_ack || (m1_as && w_tmo_hit)) begin
                    w_state_next     = ST_RELEASE;
                    w_rel_owner_next = GRANT_M1;
                end else if (!m1_as) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_RELEASE: begin
                // Wait for the finished master to drop its strobe so a held
                // strobe is never mistaken for a new request.
                if (r_rel_owner == GRANT_M0) begin
                    if (!m0_as) begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    if (!m1_as) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Scoreboard bench for bus_arbiter (TIMEOUT = 8). Stimulus pushes the expected
// response of every transfer; a monitor pops and compares whenever a master
// sees ack or berr. A small slave model acks after a programmable number of
// strobe cycles and returns read data derived from the address.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TO = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_as, m0_uds, m0_lds, m0_rw, m0_ack, m0_berr;
    logic [AW-1:0] m0_addr;
    logic [15:0]   m0_write, m0_read;
    logic          m1_as, m1_uds, m1_lds, m1_rw, m1_ack, m1_berr;
    logic [AW-1:0] m1_addr;
    logic [15:0]   m1_write, m1_read;
    logic          s_as, s_uds, s_lds, s_rw, s_ack;
    logic [AW-1:0] s_addr;
    logic [15:0]   s_write, s_read;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_as(m0_as), .m0_addr(m0_addr), .m0_write(m0_write), .m0_uds(m0_uds),
        .m0_lds(m0_lds), .m0_rw(m0_rw), .m0_read(m0_read), .m0_ack(m0_ack), .m0_berr(m0_berr),
        .m1_as(m1_as), .m1_addr(m1_addr), .m1_write(m1_write), .m1_uds(m1_uds),
        .m1_lds(m1_lds), .m1_rw(m1_rw), .m1_read(m1_read), .m1_ack(m1_ack), .m1_berr(m1_berr),
        .s_as(s_as), .s_addr(s_addr), .s_write(s_write), .s_uds(s_uds), .s_lds(s_lds),
        .s_rw(s_rw), .s_read(s_read), .s_ack(s_ack)
    );

    typedef struct {
        int          master;
        bit          rw;
        logic [31:0] addr;
        logic [15:0] wdata;
        bit          uds;
        bit          lds;
        bit          berr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   mon_m;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Slave model configuration and state.
    int   ack_delay = 2;
    int   busy_cnt  = 0;
    bit   s_as_seen = 1'b0;

    // Round-robin reference: which master won the most recent contest.
    int   model_last = 1;

    // Per-round stimulus (indexed by master).
    logic [31:0] ra[2];
    logic [15:0] rd[2];
    bit          ru[2], rl[2], rr[2];
    int          cyc_m[2];

    function automatic logic [15:0] slave_data(input logic [31:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    assign s_read = slave_data(s_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: ack after ack_delay cycles of seeing s_as, for exactly one cycle.
    initial begin
        s_ack = 1'b0;
        forever begin
            @(negedge clk);
            s_as_seen = s_as;
            @(posedge clk);
            #2;
            if (s_ack) begin
                s_ack    = 1'b0;
                busy_cnt = 0;
            end else if (s_as_seen) begin
                busy_cnt++;
                s_ack = (busy_cnt == ack_delay);
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Monitor: one scoreboard entry per ack/berr event.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_ack || m0_berr || m1_ack || m1_berr) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_resp", {m1_ack, m1_berr, m0_ack, m0_berr}, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_m = (m1_ack || m1_berr) ? 1 : 0;
                    $display("resp: master=%0d berr=%0d addr=0x%0h", mon_m,
                             (mon_m == 1) ? m1_berr : m0_berr, s_addr);
                    check("sb_master", 64'(mon_m), 64'(mon_e.master));
                    check("sb_berr", (mon_m == 1) ? m1_berr : m0_berr, 64'(mon_e.berr));
                    if (mon_m == 1) check("sb_other_quiet", {m0_ack, m0_berr, m0_read}, 64'd0);
                    else            check("sb_other_quiet", {m1_ack, m1_berr, m1_read}, 64'd0);
                    check("sb_addr", s_addr, mon_e.addr);
                    if (mon_e.berr) begin
                        check("sb_berr_sas", s_as, 64'd0);
                    end else if (mon_e.rw) begin
                        check("sb_rdata", (mon_m == 1) ? m1_read : m0_read, slave_data(mon_e.addr));
                    end else begin
                        check("sb_wbus", {s_rw, s_uds, s_lds, s_write},
                              {1'b0, mon_e.uds, mon_e.lds, mon_e.wdata});
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int id, input bit as, input logic [31:0] a,
                         input logic [15:0] d, input bit u, input bit l, input bit r);
        if (id == 0) begin
            m0_as = as; m0_addr = a; m0_write = d; m0_uds = u; m0_lds = l; m0_rw = r;
        end else begin
            m1_as = as; m1_addr = a; m1_write = d; m1_uds = u; m1_lds = l; m1_rw = r;
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] a, input logic [15:0] d,
                            input bit u, input bit l, input bit r, input bit be);
        exp_t e;
        e.master = id; e.addr = a; e.wdata = d; e.uds = u; e.lds = l; e.rw = r; e.berr = be;
        sb_q.push_back(e);
    endtask

    // Call at posedge+1. Holds the strobe until ack/berr, then drops it.
    task automatic master_txn(input int id, input logic [31:0] a, input logic [15:0] d,
                              input bit u, input bit l, input bit r, output int cyc);
        bit done = 1'b0;
        cyc = -1;
        drive(id, 1'b1, a, d, u, l, r);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((id == 0) ? (m0_ack || m0_berr) : (m1_ack || m1_berr)) begin
                cyc  = n;
                done = 1'b1;
                break;
            end
        end
        check("txn_resp_seen", done, 64'd1);
        @(posedge clk);
        #1;
        drive(id, 1'b0, a, d, 1'b0, 1'b0, r);
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        model_last = 1;
        @(posedge clk);
        #1;
    endtask

    // pat: 1 = m0 alone, 2 = m1 alone, 3 = both in the same cycle.
    task run_round(input int pat, input int dly);
        int  first, second, exp_lat;
        bit  be;
        ack_delay = dly;
        be        = (dly > TO);
        exp_lat   = be ? TO + 1 : dly + 1;
        for (int i = 0; i < 2; i++) begin
            ra[i] = $urandom;
            rd[i] = 16'($urandom);
            ru[i] = 1'($urandom);
            rl[i] = 1'($urandom);
            rr[i] = 1'($urandom);
        end
        if (pat == 3) begin
            first      = (model_last == 1) ? 0 : 1;
            second     = 1 - first;
            model_last = first;
            push_exp(first,  ra[first],  rd[first],  ru[first],  rl[first],  rr[first],  be);
            push_exp(second, ra[second], rd[second], ru[second], rl[second], rr[second], be);
            fork
                master_txn(0, ra[0], rd[0], ru[0], rl[0], rr[0], cyc_m[0]);
                master_txn(1, ra[1], rd[1], ru[1], rl[1], rr[1], cyc_m[1]);
            join
            $display("round: both, winner=m%0d delay=%0d berr=%0d", first, dly, be);
            check("rr_winner_latency", 64'(cyc_m[first]), 64'(exp_lat));
            check("rr_order", 64'(cyc_m[first] < cyc_m[second]), 64'd1);
        end else begin
            first = pat - 1;
            push_exp(first, ra[first], rd[first], ru[first], rl[first], rr[first], be);
            master_txn(first, ra[first], rd[first], ru[first], rl[first], rr[first], cyc_m[first]);
            $display("round: single m%0d delay=%0d berr=%0d", first, dly, be);
            check("single_latency", 64'(cyc_m[first]), 64'(exp_lat));
        end
        gap();
    endtask

    int dly_tab[7];
    int unused_cyc;

    initial begin
        dly_tab = '{1, 2, 3, 4, 8, 9, 20};
        drive(0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {s_as, s_uds, s_lds, m0_ack, m1_ack, m0_berr, m1_berr, m0_read, m1_read}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // m0 reads $000400 alone; slave acks on cycle 3.
        ack_delay = 2;
        push_exp(0, 32'h0000_0400, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 1'b1, 32'h0000_0400, 16'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_c0_s_as", s_as, 64'd0);
        @(negedge clk);
        check("t1_c1_s_as", s_as, 64'd1);
        check("t1_c1_s_addr", s_addr, 64'h400);
        check("t1_c1_m0_ack", m0_ack, 64'd0);
        @(negedge clk);
        check("t1_c2_m0_ack", m0_ack, 64'd0);
        @(negedge clk);
        check("t1_c3_m0_ack", m0_ack, 64'd1);
        check("t1_c3_m0_read", m0_read, 64'(slave_data(32'h0000_0400)));
        check("t1_c3_m1_quiet", {m1_ack, m1_read}, 64'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0000_0400, 16'h0, 1'b0, 1'b0, 1'b1);
        gap();

        // m0 writes $00AA to the low byte only.
        ack_delay = 1;
        push_exp(0, 32'h0000_2000, 16'h00AA, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b1, 32'h0000_2000, 16'h00AA, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_slave_bus", {s_as, s_uds, s_lds, s_rw, s_write}, {1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA});
        @(negedge clk);
        check("t6_m0_ack", m0_ack, 64'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0000_2000, 16'h00AA, 1'b0, 1'b0, 1'b0);
        gap();

        // Simultaneous requests after reset: m0 first, then m1.
        do_reset();
        run_round(3, 2);
        run_round(3, 1);

        // Slave never acks m1: berr after 8 BUSY cycles, then RELEASE holds.
        ack_delay = 1000;
        push_exp(1, 32'h0000_1234, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1, 1'b1, 32'h0000_1234, 16'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            check("t3_busy_sas_noberr", {s_as, m1_berr}, 64'b10);
        end
        @(negedge clk);
        check("t3_berr_pulse", m1_berr, 64'd1);
        check("t3_s_as_low", s_as, 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t3_release_hold", {s_as, m1_berr, m1_ack}, 64'd0);
        end
        @(posedge clk);
        #1;
        drive(1, 1'b0, 32'h0000_1234, 16'h0, 1'b0, 1'b0, 1'b1);
        gap();

        // Ack lands in the expiry cycle: ack wins, no berr.
        ack_delay = TO;
        push_exp(0, 32'h0000_5678, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        master_txn(0, 32'h0000_5678, 16'h0, 1'b1, 1'b1, 1'b1, cyc_m[0]);
        check("t4_ack_at_timeout_lat", 64'(cyc_m[0]), 64'(TO + 1));
        gap();

        // Reset while m0 is BUSY: outputs clear asynchronously.
        ack_delay = 1000;
        drive(0, 1'b1, 32'h0000_3000, 16'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before_reset", s_as, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_clear", {s_as, s_uds, s_lds, m0_ack, m0_berr, m0_read}, 64'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0000_3000, 16'h0, 1'b0, 1'b0, 1'b1);
        reset_n    = 1'b1;
        model_last = 1;
        @(posedge clk);
        #1;
        ack_delay = 1;
        push_exp(1, 32'h0000_4444, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        master_txn(1, 32'h0000_4444, 16'h0, 1'b1, 1'b1, 1'b1, cyc_m[1]);
        check("t5_m1_grant_latency", 64'(cyc_m[1]), 64'd2);
        gap();

        // Randomized rounds against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_round($urandom_range(1, 3), dly_tab[$urandom_range(0, 6)]);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
